// File: rtl/guess_if.sv
// guess_if: user-side bus of the digit-guessing FSM
interface guess_if;
    logic [3:0] digito;
    logic       confirma;
    logic [3:0] entrada;
    logic [3:0] estado;
    logic [2:0] tentativas;
    logic       erro;
    modport master (output digito, confirma, input entrada, estado, tentativas, erro);
    modport slave  (input digito, confirma, output entrada, estado, tentativas, erro);
endinterface

// File: rtl/guess_fsm.sv
// guess_fsm: four-digit code entry with match scoring, result hold and lockout
module guess_fsm #(
    parameter logic [3:0] SEG0 = 4'd1,
    parameter logic [3:0] SEG1 = 4'd2,
    parameter logic [3:0] SEG2 = 4'd3,
    parameter logic [3:0] SEG3 = 4'd4,
    parameter int HOLD_CYCLES = 16,
    parameter int MAX_TENTATIVAS = 3
) (
    input logic clk,
    input logic reset,
    guess_if.slave bus
);
    typedef enum logic [3:0] {
        ESPERA          = 4'b0000,
        D1              = 4'b0001,
        D2              = 4'b0010,
        D3              = 4'b0011,
        CHECK           = 4'b0100,
        SUCESSO_TOTAL   = 4'b0110,
        SUCESSO_PARCIAL = 4'b1101,
        FALHA           = 4'b1110,
        BLOQUEADO       = 4'b1111
    } state_t;
    localparam logic [2:0] max_t = 3'(MAX_TENTATIVAS);
    localparam logic [15:0] hold_load = 16'(HOLD_CYCLES - 1);
    state_t state, state_n;
    logic [3:0][3:0] slots, slots_n;
    logic [3:0] entrada, entrada_n;
    logic [2:0] tent, tent_n, hits;
    logic [15:0] hold, hold_n;
    logic erro, erro_n, conf_q, primed, press;
    // next state and datapath; entry states are consecutive codes so D3+1 is CHECK
    always_comb begin
        state_n = state;
        slots_n = slots;
        entrada_n = entrada;
        tent_n = tent;
        hold_n = hold;
        erro_n = 1'b0;
        press = bus.confirma & ~conf_q & primed;
        hits = 3'(slots[0] == SEG0) + 3'(slots[1] == SEG1) + 3'(slots[2] == SEG2) + 3'(slots[3] == SEG3);
        case (state)
            ESPERA, D1, D2, D3: begin
                if (press && bus.digito <= 4'd9) begin
                    slots_n[state[1:0]] = bus.digito;
                    entrada_n = bus.digito;
                    state_n = state_t'(state + 4'd1);
                end else if (press) begin
                    erro_n = 1'b1;
                end
            end
            CHECK: begin
                entrada_n = {1'b0, hits};
                hold_n = hold_load;
                state_n = hits == 3'd4 ? SUCESSO_TOTAL : hits == 3'd0 ? FALHA : SUCESSO_PARCIAL;
                tent_n = hits == 3'd4 ? 3'd0 : tent == 3'd7 ? 3'd7 : tent + 3'd1;
            end
            SUCESSO_TOTAL, SUCESSO_PARCIAL, FALHA: begin
                if (hold != 16'd0) begin
                    hold_n = hold - 16'd1;
                end else if (tent >= max_t) begin
                    state_n = BLOQUEADO;
                end else begin
                    state_n = ESPERA;
                    entrada_n = 4'd0;
                end
            end
            default: state_n = state;
        endcase
    end
    // state and datapath registers; primed masks a level held through reset release
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ESPERA;
            slots <= '0;
            entrada <= 4'd0;
            tent <= 3'd0;
            hold <= 16'd0;
            erro <= 1'b0;
            conf_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            state <= state_n;
            slots <= slots_n;
            entrada <= entrada_n;
            tent <= tent_n;
            hold <= hold_n;
            erro <= erro_n;
            conf_q <= bus.confirma;
            primed <= 1'b1;
        end
    end
    assign bus.estado = state;
    assign bus.entrada = entrada;
    assign bus.tentativas = tent;
    assign bus.erro = erro;
endmodule

// File: tb/tb_guess_fsm.sv
// tb_guess_fsm: directed stimulus with a queue-based reference model checked every cycle
module tb_guess_fsm;
    logic clk = 1'b0;
    logic reset;
    logic go = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    guess_if bus ();
    guess_fsm dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    localparam int HOLD = 16;
    localparam int MAXT = 3;
    int secret[4] = '{1, 2, 3, 4};
    int digits[$];
    int res_code = -1;
    int hold_left = 0;
    int tries = 0;
    bit locked = 1'b0;
    int m_entrada = 0;
    bit m_erro = 1'b0;
    bit prev_conf = 1'b0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_estado();
        if (locked) return 15;
        if (res_code >= 0) return res_code;
        return digits.size();
    endfunction

    // reference model: collected digits, pending result and remaining hold time
    always @(posedge clk) begin
        if (reset) begin
            digits.delete();
            res_code = -1;
            hold_left = 0;
            tries = 0;
            locked = 1'b0;
            m_entrada = 0;
            m_erro = 1'b0;
            prev_conf = 1'b0;
            armed = 1'b0;
        end else begin
            bit pressed;
            int hits;
            pressed = bus.confirma && !prev_conf && armed;
            prev_conf = bus.confirma;
            armed = 1'b1;
            m_erro = 1'b0;
            if (locked) begin
            end else if (res_code >= 0) begin
                if (hold_left == 1) begin
                    res_code = -1;
                    if (tries >= MAXT) locked = 1'b1;
                    else begin
                        m_entrada = 0;
                        digits.delete();
                    end
                end else hold_left--;
            end else if (digits.size() == 4) begin
                hits = 0;
                foreach (digits[i]) if (digits[i] == secret[i]) hits++;
                m_entrada = hits;
                res_code = hits == 4 ? 6 : hits == 0 ? 14 : 13;
                tries = hits == 4 ? 0 : (tries < 7 ? tries + 1 : 7);
                hold_left = HOLD;
            end else if (pressed) begin
                if (bus.digito <= 9) begin
                    digits.push_back(int'(bus.digito));
                    m_entrada = int'(bus.digito);
                end else m_erro = 1'b1;
            end
        end
    end

    // compare every cycle away from the active edge
    always @(negedge clk) begin
        if (go) begin
            check("estado", 32'(bus.estado), 32'(m_estado()));
            check("entrada", 32'(bus.entrada), 32'(m_entrada));
            check("tentativas", 32'(bus.tentativas), 32'(tries));
            check("erro", 32'(bus.erro), 32'(m_erro));
        end
    end

    task automatic press(input logic [3:0] d);
        bus.digito = d;
        bus.confirma = 1'b1;
        @(negedge clk);
        bus.confirma = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.confirma = 1'b0;
        bus.digito = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        go = 1'b1;
        check("rst_estado", 32'(bus.estado), 0);
        check("rst_entrada", 32'(bus.entrada), 0);
        check("rst_tent", 32'(bus.tentativas), 0);
        check("rst_erro", 32'(bus.erro), 0);
        @(negedge clk);
        press(4'd1);
        check("t1_d1", 32'(bus.estado), 1);
        press(4'd2);
        check("t1_d2", 32'(bus.estado), 2);
        press(4'd3);
        check("t1_d3", 32'(bus.estado), 3);
        bus.digito = 4'd4;
        bus.confirma = 1'b1;
        @(negedge clk);
        check("t1_check", 32'(bus.estado), 4);
        bus.confirma = 1'b0;
        @(negedge clk);
        check("t1_total", 32'(bus.estado), 6);
        check("t1_entrada", 32'(bus.entrada), 4);
        check("t1_tent", 32'(bus.tentativas), 0);
        repeat (15) @(negedge clk);
        check("t1_hold_last", 32'(bus.estado), 6);
        @(negedge clk);
        check("t1_back", 32'(bus.estado), 0);
        check("t1_entrada_clr", 32'(bus.entrada), 0);
        press(4'd1);
        press(4'd9);
        press(4'd9);
        press(4'd4);
        check("t2_parcial", 32'(bus.estado), 13);
        check("t2_entrada", 32'(bus.entrada), 2);
        check("t2_tent", 32'(bus.tentativas), 1);
        repeat (16) @(negedge clk);
        check("t2_back", 32'(bus.estado), 0);
        press(4'd1);
        press(4'd2);
        check("rst_d2_pre", 32'(bus.estado), 2);
        do_reset();
        check("rst_d2_estado", 32'(bus.estado), 0);
        check("rst_d2_entrada", 32'(bus.entrada), 0);
        check("rst_d2_tent", 32'(bus.tentativas), 0);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            press(4'd5);
            press(4'd6);
            press(4'd7);
            press(4'd8);
            check("t3_falha", 32'(bus.estado), 14);
            check("t3_tent", 32'(bus.tentativas), 32'(k));
            repeat (16) @(negedge clk);
            check("t3_after", 32'(bus.estado), k < 3 ? 0 : 15);
        end
        press(4'd12);
        press(4'd3);
        repeat (100) @(negedge clk);
        check("t3_locked", 32'(bus.estado), 15);
        do_reset();
        check("rst_blk_estado", 32'(bus.estado), 0);
        check("rst_blk_entrada", 32'(bus.entrada), 0);
        check("rst_blk_tent", 32'(bus.tentativas), 0);
        @(negedge clk);
        press(4'd1);
        bus.digito = 4'd12;
        bus.confirma = 1'b1;
        @(negedge clk);
        check("t4_erro", 32'(bus.erro), 1);
        check("t4_estado", 32'(bus.estado), 1);
        check("t4_entrada", 32'(bus.entrada), 1);
        bus.confirma = 1'b0;
        @(negedge clk);
        check("t4_erro_off", 32'(bus.erro), 0);
        bus.digito = 4'd5;
        bus.confirma = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.confirma = 1'b0;
        check("rst_prio_estado", 32'(bus.estado), 0);
        check("rst_prio_entrada", 32'(bus.entrada), 0);
        @(negedge clk);
        bus.digito = 4'd6;
        bus.confirma = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        check("held_rst", 32'(bus.estado), 0);
        bus.confirma = 1'b0;
        @(negedge clk);
        bus.digito = 4'd7;
        bus.confirma = 1'b1;
        repeat (50) @(negedge clk);
        check("t5_estado", 32'(bus.estado), 1);
        check("t5_entrada", 32'(bus.entrada), 7);
        bus.confirma = 1'b0;
        @(negedge clk);
        check("t5_after", 32'(bus.estado), 1);
        go = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
